spi_frame_queue: RTL and testbench
==================================

Name: spi_frame_queue

Overview:
Parametrised successor to the single-frame SPI write formatter. It builds (address, register, data) frames for an MCP23S17-style SPI GPIO expander from init and write requests, and buffers them in a small FIFO. It then issues them one at a time to the downstream SPI master through a send/idle handshake. It adds multi-device hardware addressing, queueing, a start timeout, and error and status reporting.

Parameters:
DEPTH, 4, frame FIFO depth; power of two, 2..16
DEV_BITS, 3, width of device select; addresses 2**DEV_BITS expanders
BASE_ADDR, 8'h40, opcode base; write opcode = BASE_ADDR | (dev_sel << 1)
INIT_REG, 8'h00, register written by an init request (IODIR)
INIT_DATA, 8'h00, data written by an init request
WRITE_REG, 8'h12, register written by a write request (GPIO)
TIMEOUT, 16, cycles to wait for idle to drop after send before declaring a start failure

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
init_req  in  1  one-cycle pulse; enqueue an init frame
write_req  in  1  one-cycle pulse; enqueue a write frame with data_i
dev_sel  in  DEV_BITS  target expander, sampled with the request
data_i  in  8  write payload, sampled with write_req
idle  in  1  SPI master idle (1 = ready / finished)
address  out  8  opcode byte of the active frame
register  out  8  register byte of the active frame
data  out  8  data byte of the active frame
send  out  1  one-cycle start strobe to the SPI master
busy  out  1  frame in flight (state != S_IDLE)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(DEPTH)+1  FIFO occupancy
drop  out  1  one-cycle pulse; request rejected
overflow  out  1  sticky: any request dropped because FIFO was full
timeout_err  out  1  sticky: a frame failed to start

Behaviour:
- Reset (rst=1 at clk edge): FIFO empty, count=0, state S_IDLE, and every output is 0 except empty=1. Reset mid-transaction abandons the frame; queued frames are lost.
- Enqueue:
  - init_req has priority. It pushes {BASE_ADDR|dev_sel<<1, INIT_REG, INIT_DATA}.
  - Otherwise write_req pushes {BASE_ADDR|dev_sel<<1, WRITE_REG, data_i}.
  - If both are high, init is pushed, write is rejected, and drop pulses.
- Full: a push is rejected when full (evaluated before any same-cycle pop). The rejection pulses drop and sets overflow. The FIFO contents are unchanged.
- Push and pop in the same non-full cycle: both take effect, and count is unchanged.
- Issue FSM:
  - S_IDLE: if !empty and idle, pop the head into the output registers, pulse send for exactly 1 cycle (the cycle after the pop decision), start the timeout counter, and go to S_START.
  - S_START: if idle==0, go to S_RUN. If the counter reaches TIMEOUT, set timeout_err, clear the outputs, and go to S_IDLE. The frame is discarded, not retried.
  - S_RUN: when idle==1, clear address/register/data to 0 on the next edge and go to S_IDLE.
- Output stability: address, register and data are constant from the send cycle until the frame completes or times out. They are 0 in S_IDLE.
- Back-to-back issue: minimum 1 S_IDLE cycle between frames.
- Requests arriving while busy are queued and are not lost unless the FIFO is full.
- count, empty and full update on the clock edge after a push or pop.

Decomposition:
- Package spi_frame_pkg:
  - typedef frame_t (packed struct addr/reg/data, 24 bits)
  - state enum {S_IDLE, S_START, S_RUN}
  - MCP23S17 register constants (IODIR=8'h00, GPIO=8'h12, OLAT=8'h14)
- One sub-module: sync_fifo (parametrised WIDTH/DEPTH, synchronous active-high rst, push/pop/full/empty/count).

Test Plan:
1. Reset then idle=1, init_req with dev_sel=0 -> one cycle later send=1, with address=0x40, register=0x00, data=0x00. Model drops idle for 8 cycles -> outputs return to 0 after idle rises.
2. write_req with data_i=0xA5, dev_sel=3 -> address=0x46, register=0x12, data=0xA5. Outputs stay stable across the whole busy window.
3. Hold idle=0 and issue 5 write_req (DEPTH=4) -> count=4, full=1. The 5th raises drop and overflow=1. Release idle -> 4 frames issue in order with matching data.
4. init_req and write_req in the same cycle -> one init frame queued, drop=1, count=1.
5. Send issued but idle never drops -> after 16 cycles timeout_err=1, outputs=0, next queued frame then issues normally.
6. Assert rst during S_RUN with 2 frames queued -> next cycle all outputs 0, empty=1, and no send follows.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame queue.
//   frame_t : one SPI write frame {opcode, register, data}, 24 bits
//   state_t : issue FSM states
//   IODIR/GPIO/OLAT : MCP23S17 register addresses (IOCON.BANK=0)
package spi_frame_pkg;

  localparam logic [7:0] IODIR = 8'h00;
  localparam logic [7:0] GPIO  = 8'h12;
  localparam logic [7:0] OLAT  = 8'h14;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } frame_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. dout always presents the head entry.
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write request and data (ignored when full)
//   pop         : read request (ignored when empty)
//   dout        : head entry
//   full, empty : occupancy flags
//   count       : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/spi_frame_queue.sv
// Builds MCP23S17 write frames from init/write requests, queues them and
// hands them one at a time to an SPI master over a send/idle handshake.
//   clk, rst            : clock, synchronous active-high reset
//   init_req, write_req : request pulses (init wins when both are high)
//   dev_sel, data_i     : target expander and write payload
//   idle                : SPI master ready/finished
//   address/register/data : active frame, 0 when no frame in flight
//   send                : one-cycle start strobe
//   busy, empty, full, count : status
//   drop                : pulse, request rejected
//   overflow, timeout_err : sticky error flags
module spi_frame_queue
  import spi_frame_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DEV_BITS  = 3,
  parameter logic [7:0]  BASE_ADDR = 8'h40,
  parameter logic [7:0]  INIT_REG  = IODIR,
  parameter logic [7:0]  INIT_DATA = 8'h00,
  parameter logic [7:0]  WRITE_REG = GPIO,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_req,
  input  logic                    write_req,
  input  logic [DEV_BITS-1:0]     dev_sel,
  input  logic [7:0]              data_i,
  input  logic                    idle,
  output logic [7:0]              address,
  output logic [7:0]              register,
  output logic [7:0]              data,
  output logic                    send,
  output logic                    busy,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    drop,
  output logic                    overflow,
  output logic                    timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state, state_n;
  frame_t        frame_q, frame_n;
  frame_t        push_frame;
  frame_t        head;
  logic [TW-1:0] timer, timer_n;
  logic          send_q, send_n;
  logic          tmo_q, tmo_n;
  logic          drop_q, ovf_q;
  logic          push;
  logic          pop;

  assign push = init_req || write_req;

  always_comb begin
    push_frame.addr     = BASE_ADDR | 8'({dev_sel, 1'b0});
    push_frame.reg_addr = init_req ? INIT_REG  : WRITE_REG;
    push_frame.data     = init_req ? INIT_DATA : data_i;
  end

  // full is sampled before any same-cycle pop, so a push into a full FIFO
  // is rejected even when the head leaves in the same cycle.
  sync_fifo #(
    .WIDTH ($bits(frame_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_frame),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      frame_q <= '0;
      timer   <= '0;
      send_q  <= 1'b0;
      tmo_q   <= 1'b0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      frame_q <= frame_n;
      timer   <= timer_n;
      send_q  <= send_n;
      tmo_q   <= tmo_n;
      drop_q  <= (init_req && write_req) || (push && full);
      if (push && full) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    frame_n = frame_q;
    timer_n = timer;
    send_n  = 1'b0;
    tmo_n   = tmo_q;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && idle) begin
          pop     = 1'b1;
          frame_n = head;
          send_n  = 1'b1;
          timer_n = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        // The send cycle is the first of TIMEOUT cycles allowed for idle to drop.
        if (!idle) begin
          state_n = S_RUN;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          tmo_n   = 1'b1;
          frame_n = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_RUN: begin
        if (idle) begin
          frame_n = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign address     = frame_q.addr;
  assign register    = frame_q.reg_addr;
  assign data        = frame_q.data;
  assign send        = send_q;
  assign busy        = (state != S_IDLE);
  assign drop        = drop_q;
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_spi_frame_queue.sv
// Bench for spi_frame_queue: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level queue model.
module tb_spi_frame_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DEV_BITS = 3;
  localparam int unsigned TIMEOUT  = 16;
  localparam logic [7:0]  BASE     = 8'h40;
  localparam logic [7:0]  I_REG    = 8'h00;
  localparam logic [7:0]  I_DATA   = 8'h00;
  localparam logic [7:0]  W_REG    = 8'h12;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  init_req, write_req;
  logic [DEV_BITS-1:0]   dev_sel;
  logic [7:0]            data_i;
  logic                  idle = 1'b1;
  logic [7:0]            address, register, data;
  logic                  send, busy, empty, full, drop, overflow, timeout_err;
  logic [$clog2(DEPTH):0] count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  spi_frame_queue #(
    .DEPTH     (DEPTH),
    .DEV_BITS  (DEV_BITS),
    .BASE_ADDR (BASE),
    .INIT_REG  (I_REG),
    .INIT_DATA (I_DATA),
    .WRITE_REG (W_REG),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init_req    (init_req),
    .write_req   (write_req),
    .dev_sel     (dev_sel),
    .data_i      (data_i),
    .idle        (idle),
    .address     (address),
    .register    (register),
    .data        (data),
    .send        (send),
    .busy        (busy),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .drop        (drop),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [23:0] mq[$];
  logic [23:0] m_cur = '0;
  bit          m_busy = 0, m_started = 0;
  int          m_age = 0;
  bit          e_send = 0, e_drop = 0, e_ovf = 0, e_tmo = 0;

  always @(posedge clk) begin
    int n0;
    if (rst) begin
      mq.delete();
      m_cur = '0; m_busy = 0; m_started = 0; m_age = 0;
      e_send = 0; e_drop = 0; e_ovf = 0; e_tmo = 0;
    end else begin
      n0 = mq.size();
      e_send = 0;
      if (m_busy) begin
        if (m_started) begin
          if (idle) begin m_busy = 0; m_cur = '0; end
        end else if (!idle) begin
          m_started = 1;
        end else begin
          m_age++;
          if (m_age == TIMEOUT) begin e_tmo = 1; m_busy = 0; m_cur = '0; end
        end
      end else if (n0 > 0 && idle) begin
        m_cur = mq.pop_front();
        m_busy = 1; m_started = 0; m_age = 0; e_send = 1;
      end
      e_drop = (init_req && write_req) || ((init_req || write_req) && n0 == DEPTH);
      if ((init_req || write_req) && n0 == DEPTH) e_ovf = 1;
      else if (init_req)  mq.push_back({BASE + 8'(dev_sel) * 8'd2, I_REG, I_DATA});
      else if (write_req) mq.push_back({BASE + 8'(dev_sel) * 8'd2, W_REG, data_i});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("address",  32'(address),     32'(m_cur[23:16]));
      check("register", 32'(register),    32'(m_cur[15:8]));
      check("data",     32'(data),        32'(m_cur[7:0]));
      check("send",     32'(send),        32'(e_send));
      check("busy",     32'(busy),        32'(m_busy));
      check("count",    32'(count),       32'(mq.size()));
      check("empty",    32'(empty),       32'(mq.size() == 0));
      check("full",     32'(full),        32'(mq.size() == DEPTH));
      check("drop",     32'(drop),        32'(e_drop));
      check("overflow", 32'(overflow),    32'(e_ovf));
      check("timeout",  32'(timeout_err), 32'(e_tmo));
    end
  end

  // ---------------- SPI master responder ----------------
  // mode 0: drop idle for a burst after each send; 1: hold idle low;
  // 2: never respond (idle stays high).
  int mode = 0, bcnt = 0, rlen = 8;
  bit rand_len = 0;

  always @(negedge clk) begin
    if (mode == 1) idle = 1'b0;
    else if (mode == 2) idle = 1'b1;
    else if (bcnt > 0) begin
      bcnt--;
      idle = (bcnt == 0);
    end else if (send === 1'b1) begin
      bcnt = rand_len ? int'($urandom_range(1, 6)) : rlen;
      idle = 1'b0;
    end else idle = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input bit i, input bit w, input int d, input logic [7:0] v);
    @(negedge clk);
    init_req = i; write_req = w; dev_sel = DEV_BITS'(d); data_i = v;
    @(negedge clk);
    init_req = 0; write_req = 0;
  endtask

  function automatic bit cond(input int what);
    case (what)
      0:       return send === 1'b1;
      1:       return busy === 1'b0 && empty === 1'b1;
      default: return timeout_err === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int what, input int maxc, input string name);
    int n = 0;
    while (!cond(what) && n < maxc) begin @(negedge clk); n++; end
    if (!cond(what)) begin
      checks++; errors++;
      $display("FAIL %s: condition not reached within %0d cycles", name, maxc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    init_req = 0; write_req = 0; dev_sel = '0; data_i = '0; rst = 1;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr",  32'(address), 32'd0);
    rst = 0;

    // 1: init frame to device 0
    mode = 0; rlen = 8;
    req(1, 0, 0, 8'h00);
    @(negedge clk);
    check("t1_send", 32'(send), 32'd1);
    check("t1_addr", 32'(address), 32'h40);
    check("t1_reg",  32'(register), 32'h00);
    check("t1_data", 32'(data), 32'h00);
    wait_for(1, 40, "t1_done");
    check("t1_clear", 32'(address), 32'd0);

    // 2: write to device 3
    req(0, 1, 3, 8'hA5);
    @(negedge clk);
    check("t2_addr", 32'(address), 32'h46);
    check("t2_reg",  32'(register), 32'h12);
    check("t2_data", 32'(data), 32'hA5);
    wait_for(1, 40, "t2_done");

    // 3: fill while the master is held busy, fifth request overflows
    mode = 1;
    for (int i = 0; i < 5; i++) req(0, 1, i, 8'h10 + 8'(i));
    check("t3_drop",  32'(drop), 32'd1);
    check("t3_ovf",   32'(overflow), 32'd1);
    check("t3_count", 32'(count), 32'd4);
    check("t3_full",  32'(full), 32'd1);
    mode = 0;
    wait_for(1, 200, "t3_drain");

    // 4: simultaneous init and write
    req(1, 1, 1, 8'h33);
    check("t4_drop",  32'(drop), 32'd1);
    check("t4_count", 32'(count), 32'd1);
    wait_for(1, 40, "t4_done");

    // 5: start timeout, then the next frame issues normally
    mode = 1;
    req(0, 1, 2, 8'h11);
    req(0, 1, 5, 8'h22);
    mode = 2;
    wait_for(0, 10, "t5_send");
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("t5_latency", 32'(n), 32'(TIMEOUT));
    check("t5_clear",   32'(address), 32'd0);
    mode = 0;
    wait_for(0, 10, "t5_next");
    check("t5_addr", 32'(address), 32'h4A);
    check("t5_data", 32'(data), 32'h22);
    wait_for(1, 40, "t5_done");

    // 6: reset during a transfer with two frames queued
    rlen = 20;
    req(0, 1, 1, 8'h61);
    req(0, 1, 2, 8'h62);
    req(0, 1, 3, 8'h63);
    check("t6_count", 32'(count), 32'd2);
    check("t6_busy",  32'(busy), 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_addr",  32'(address), 32'd0);
    check("t6_busy0", 32'(busy), 32'd0);
    saw = 0;
    repeat (30) begin @(negedge clk); if (send === 1'b1) saw = 1; end
    check("t6_nosend", 32'(saw), 32'd0);

    // randomized traffic with held-busy and unresponsive windows
    rand_len = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      mode = (c >= 400 && c < 550) ? 1 : (c >= 900 && c < 1000) ? 2 : 0;
      init_req  = ($urandom_range(0, 7) == 0);
      write_req = ($urandom_range(0, 2) == 0);
      dev_sel   = DEV_BITS'($urandom);
      data_i    = 8'($urandom);
    end
    @(negedge clk);
    init_req = 0; write_req = 0; mode = 0;
    wait_for(1, 400, "final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
